mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between an instruction-fetch requester and a
// load/store data requester. A three-state FSM (IDLE, GRANT_I, GRANT_D) picks
// a winner in IDLE, holds the memory request stable until mem_ack, then
// returns read data and a one-cycle ready pulse to the winning port.
//
// Default arbitration is strict data-over-fetch priority. A requester whose
// own ready output is high in the arbitration cycle is not eligible, so a
// request still held after completion is not granted again at once.
//
// Optional feature (macro ARB_FETCH_FAIR_EN):
//   A 2-bit counter tracks consecutive data grants made while if_req was
//   high. Once it reaches 3, the next arbitration grants fetch (if eligible)
//   regardless of d_req. The counter clears on any fetch grant, or on a data
//   grant made while if_req was low. Without the macro no counter exists.
//
// Ports:
//   CLK        in   1   rising-edge clock
//   rst        in   1   asynchronous reset, active-low
//   if_req     in   1   fetch access request
//   if_addr    in  32   fetch address
//   if_rdata   out 32   fetch read data (held until next fetch completion)
//   if_ready   out  1   fetch completion pulse (one cycle)
//   d_req      in   1   data access request
//   d_we       in   1   1 = store, 0 = load
//   d_addr     in  32   data address
//   d_wdata    in  32   store data
//   d_rdata    out 32   load data (held until next data load completion)
//   d_ready    out  1   data completion pulse (one cycle)
//   mem_req    out  1   memory access valid
//   mem_we     out  1   memory write strobe
//   mem_addr   out 32   memory address
//   mem_wdata  out 32   memory write data
//   mem_rdata  in  32   memory read data
//   mem_ack    in   1   memory access complete, mem_rdata valid
// -----------------------------------------------------------------------------
module mem_arbiter (
  input  logic        CLK,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  state_e      state_q,     state_d;
  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic [31:0] d_rdata_q,   d_rdata_d;
  logic        if_ready_q,  if_ready_d;
  logic        d_ready_q,   d_ready_d;

  // Arbitration terms. A port is eligible only when it requests and is not
  // currently presenting its own completion pulse.
  logic i_elig;
  logic d_elig;
  logic grant_i;
  logic grant_d;

`ifdef ARB_FETCH_FAIR_EN
  logic [1:0] fair_cnt_q, fair_cnt_d;
  logic       fair_force;
`endif

  always_comb begin
    i_elig = if_req & ~if_ready_q;
    d_elig = d_req  & ~d_ready_q;
`ifdef ARB_FETCH_FAIR_EN
    // After three back-to-back data grants that kept fetch waiting, fetch
    // wins the next arbitration if it is able to take it.
    fair_force = (fair_cnt_q == 2'd3) & i_elig;
    grant_d    = d_elig & ~fair_force;
`else
    grant_d    = d_elig;
`endif
    grant_i    = i_elig & ~grant_d;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    // Ready outputs are pulses: low unless a completion happens this cycle.
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // mem_ack is deliberately not looked at here.
        if (grant_d) begin
          state_d     = GRANT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d     = GRANT_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end

      GRANT_I: begin
        // Request inputs are not consulted: a dropped if_req still completes.
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
        end
      end

      GRANT_D: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          // Stores leave the load-data register untouched.
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
          d_ready_d = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

`ifdef ARB_FETCH_FAIR_EN
  // Fairness counter: saturates at 3 so that a run of data grants while fetch
  // is momentarily ineligible keeps the pending fetch boost.
  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (state_q == IDLE) begin
      if (grant_i) begin
        fair_cnt_d = '0;
      end else if (grant_d) begin
        if (if_req) begin
          fair_cnt_d = (fair_cnt_q == 2'd3) ? 2'd3 : fair_cnt_q + 2'd1;
        end else begin
          fair_cnt_d = '0;
        end
      end
    end
  end
`endif

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
`ifdef ARB_FETCH_FAIR_EN
      fair_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
`ifdef ARB_FETCH_FAIR_EN
      fair_cnt_q  <= fair_cnt_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;

endmodule
